// File: rtl/io_bridge_pkg.sv
// Shared state encoding and default constants for the I/O window bridge arbiter.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_NACK,
    ST_WR_POST
  } state_e;

  localparam int          DEF_WIN_BITS = 20;
  localparam logic [11:0] DEF_IO_BASE  = 12'hFD0;
  localparam int          DEF_TIMEOUT  = 255;
  localparam int          TMR_W        = 16;

endpackage

// File: rtl/io_bridge_arb_rr_arbiter.sv
// Round-robin arbiter: searches from the port after the last grant and
// advances its pointer only when the grant is actually taken.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic [IW-1:0] last_o
);

  logic [IW-1:0] last_q, last_d;

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = last_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_q) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  always_comb begin
    last_d = en_i ? idx_o : last_q;
  end

  // Pointer starts at the top port so the first search after reset lands on port 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/io_bridge_arb.sv
// Arbitrates several CPU-side bus ports onto one device-side port for a fixed
// I/O address window, with timeout error termination and optional posted writes.
module io_bridge_arb
  import io_bridge_pkg::*;
#(
  parameter  int                        NPORTS    = 2,
  parameter  int                        DW        = 32,
  parameter  int                        AW        = 32,
  parameter  int                        WIN_BITS  = DEF_WIN_BITS,
  parameter  logic [AW-WIN_BITS-1:0]    IO_BASE   = DEF_IO_BASE,
  parameter  int                        TIMEOUT   = DEF_TIMEOUT,
  parameter  bit                        POSTED_WR = 1'b0,
  localparam int                        SW        = DW / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NPORTS-1:0]      s_cyc_i,
  input  logic [NPORTS-1:0]      s_stb_i,
  input  logic [NPORTS-1:0]      s_we_i,
  input  logic [NPORTS*SW-1:0]   s_sel_i,
  input  logic [NPORTS*AW-1:0]   s_adr_i,
  input  logic [NPORTS*DW-1:0]   s_dat_i,
  output logic [NPORTS-1:0]      s_ack_o,
  output logic [NPORTS-1:0]      s_err_o,
  output logic [NPORTS*DW-1:0]   s_dat_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [SW-1:0]          m_sel_o,
  output logic [AW-1:0]          m_adr_o,
  output logic [DW-1:0]          m_dat_o,
  input  logic                   m_ack_i,
  input  logic [DW-1:0]          m_dat_i
);

  localparam int               IW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic                   m_cyc_q, m_cyc_d;
  logic                   m_we_q, m_we_d;
  logic [SW-1:0]          m_sel_q, m_sel_d;
  logic [AW-1:0]          m_adr_q, m_adr_d;
  logic [DW-1:0]          m_dat_q, m_dat_d;
  logic [NPORTS-1:0]      s_ack_q, s_ack_d;
  logic [NPORTS-1:0]      s_err_q, s_err_d;
  logic [NPORTS*DW-1:0]   s_dat_q, s_dat_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;

  logic [NPORTS-1:0]      req;
  logic [NPORTS-1:0]      gnt;
  logic [IW-1:0]          gnt_idx;
  logic [IW-1:0]          cur;
  logic                   grant_en;
  logic                   timed_out;
  logic                   drop;

  always_comb begin
    req = '0;
    for (int p = 0; p < NPORTS; p++) begin
      req[p] = s_cyc_i[p] & s_stb_i[p] &
               (s_adr_i[p*AW+WIN_BITS +: AW-WIN_BITS] == IO_BASE);
    end
  end

  assign grant_en  = (state_q == ST_IDLE) & ~m_ack_i & (|gnt);
  assign timed_out = (tmr_q == TMO);

  // The arbiter's last-grant pointer doubles as the index of the port being served.
  rr_arbiter #(
    .N (NPORTS)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req),
    .en_i   (grant_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .last_o (cur)
  );

  always_comb begin
    state_d = state_q;
    m_cyc_d = m_cyc_q;
    m_we_d  = m_we_q;
    m_sel_d = m_sel_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    s_ack_d = s_ack_q;
    s_err_d = s_err_q;
    s_dat_d = s_dat_q;
    tmr_d   = tmr_q;
    drop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          m_cyc_d = 1'b1;
          m_we_d  = s_we_i[gnt_idx];
          m_sel_d = s_sel_i[gnt_idx*SW +: SW];
          m_dat_d = s_dat_i[gnt_idx*DW +: DW];
          m_adr_d = {IO_BASE, s_adr_i[gnt_idx*AW +: WIN_BITS]};
          tmr_d   = '0;
          if (POSTED_WR && s_we_i[gnt_idx]) begin
            s_ack_d[gnt_idx] = 1'b1;
            state_d          = ST_WR_POST;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (m_ack_i) begin
          s_dat_d[cur*DW +: DW] = m_dat_i;
          s_ack_d[cur]          = 1'b1;
          drop                  = 1'b1;
          state_d               = ST_WAIT_NACK;
        end else if (!s_cyc_i[cur]) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else if (timed_out) begin
          s_err_d[cur]          = 1'b1;
          s_dat_d[cur*DW +: DW] = '0;
          drop                  = 1'b1;
          state_d               = ST_WAIT_NACK;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_WAIT_NACK: begin
        if (!s_stb_i[cur]) begin
          s_ack_d[cur]          = 1'b0;
          s_err_d[cur]          = 1'b0;
          s_dat_d[cur*DW +: DW] = '0;
          state_d               = ST_IDLE;
        end
      end

      ST_WR_POST: begin
        if (!s_stb_i[cur]) begin
          s_ack_d[cur] = 1'b0;
        end
        // A silent device on a posted write is simply released; the CPU already has its ack.
        if (m_cyc_q) begin
          if (m_ack_i || timed_out) begin
            drop = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        if (!s_ack_d[cur] && (drop || !m_cyc_q)) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (drop) begin
      m_cyc_d = 1'b0;
      m_we_d  = 1'b0;
      m_sel_d = '0;
      m_dat_d = '0;
      m_adr_d = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      m_cyc_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= '0;
      m_adr_q <= '1;
      m_dat_q <= '0;
      s_ack_q <= '0;
      s_err_q <= '0;
      s_dat_q <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      m_cyc_q <= m_cyc_d;
      m_we_q  <= m_we_d;
      m_sel_q <= m_sel_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      s_ack_q <= s_ack_d;
      s_err_q <= s_err_d;
      s_dat_q <= s_dat_d;
      tmr_q   <= tmr_d;
    end
  end

  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign m_we_o  = m_we_q;
  assign m_sel_o = m_sel_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign s_ack_o = s_ack_q;
  assign s_err_o = s_err_q;
  assign s_dat_o = s_dat_q;

endmodule
